// File: rtl/rr_four_source_sched_pkg.sv
// Shared constants and the round-robin pick helper for the four-source scheduler.
package rr_four_source_sched_pkg;

    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // First requester at or after ptr, wrapping modulo NUM_SRC; returns ptr when nothing is requested.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                                 input logic [SEL_W-1:0]   ptr);
        logic [SEL_W-1:0] idx;
        rr_pick = ptr;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/four_one_mux.sv
// Plain 4:1 data mux; the scheduler drives its select with the combinational winner.
module four_one_mux #(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        case (s)
            2'd0:    dout = a;
            2'd1:    dout = b;
            2'd2:    dout = c;
            default: dout = d;
        endcase
    end

endmodule

// File: rtl/rr_four_source_sched.sv
// Round-robin scheduler for four sources: captures the winning word into a
// one-deep holding register and offers it downstream over valid/ready.
module rr_four_source_sched
    import rr_four_source_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    input  logic [WIDTH-1:0]   d,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_SRC-1:0] ack
);

    logic [0:0]         state_q, state_d;
    logic [SEL_W-1:0]   ptr_q,   ptr_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [NUM_SRC-1:0] ack_q,   ack_d;

    logic               handshake;
    logic               opportunity;
    logic [SEL_W-1:0]   ptr_eff;
    logic [SEL_W-1:0]   winner;
    logic [WIDTH-1:0]   mux_dout;

    assign handshake   = (state_q == ST_HOLD) && out_ready;
    assign opportunity = (state_q == ST_IDLE) || out_ready;

    // A completing transfer moves priority past the source just served, and the
    // same-edge re-arbitration must already see that rotated pointer.
    assign ptr_eff = handshake ? (sel_q + SEL_W'(1)) : ptr_q;
    assign winner  = rr_pick(req, ptr_eff);

    four_one_mux #(.WIDTH(WIDTH)) u_mux (
        .s    (winner),
        .a    (a),
        .b    (b),
        .c    (c),
        .d    (d),
        .dout (mux_dout)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        ack_d   = '0;
        if (opportunity) begin
            ptr_d = ptr_eff;
            if (|req) begin
                state_d = ST_HOLD;
                sel_d   = winner;
                data_d  = mux_dout;
                ack_d   = NUM_SRC'(1) << winner;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = data_q;
    assign sel       = sel_q;
    assign ack       = ack_q;

endmodule

// File: doc/rr_four_source_sched.md
Name: rr_four_source_sched

Overview:
- Upstream scheduler for the 4:1 data mux `four_one_mux`. Four 4-bit sources raise requests, and this block picks one with round-robin fairness.
- It drives the mux select and registers the selected word.
- It presents the word to the downstream consumer over a valid/ready handshake.
- Each source gets a one-cycle ack pulse when its word has been captured.

Parameters:
- WIDTH, 4, data width of each source and of out_data. Must match the four_one_mux data width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on rising edge of clk.
- req  input  4  per-source request; bit i corresponds to source i (a=0, b=1, c=2, d=3).
- a  input  WIDTH  source 0 data.
- b  input  WIDTH  source 1 data.
- c  input  WIDTH  source 2 data.
- d  input  WIDTH  source 3 data.
- out_ready  input  1  downstream accepts out_data when out_valid && out_ready.
- out_valid  output  1  out_data holds a captured word.
- out_data  output  WIDTH  registered selected word.
- sel  output  2  registered index of the current/last granted source; drives mux select for external observers.
- ack  output  4  one-hot, one-cycle pulse to the source whose data was just captured.

Behaviour:
- Reset (rst_n low at a clk edge) sets:
  - out_valid=0, out_data=0, sel=2'b00, ack=4'b0000;
  - priority pointer ptr=0, with source 0 highest priority;
  - state IDLE.
- Reset mid-transfer discards the held word without completing the handshake and without advancing ptr.
- States:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1, word pending.
- Arbitration:
  - Combinational winner = first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The winner index drives the internal four_one_mux select; mux output is the capture data.
- An arbitration "opportunity" is any edge where state==IDLE, or where state==HOLD && out_ready==1.
- At an opportunity edge with any req set:
  - state <- HOLD, out_valid <- 1;
  - sel <- winner, out_data <- mux(winner) data sampled that cycle;
  - ack <- onehot(winner) for exactly the next cycle.
- Latency: req seen at edge t gives out_valid high and ack pulse during cycle t+1.
- At an opportunity edge with no req:
  - state <- IDLE, out_valid <- 0, ack <- 0;
  - sel and out_data hold their last values.
- Pointer update: on every completed handshake (HOLD && out_ready at an edge), ptr <- sel+1 mod 4, where sel is the transferred index.
  - The same-edge re-arbitration uses this new ptr.
  - Result: back-to-back transfers, one per cycle while out_ready stays high, with strict rotation among active requesters.
- Stall: in HOLD with out_ready=0, out_data, sel and out_valid are stable. ack is 0 after its single pulse. Changes on req/a..d are ignored.
- req[i] dropping after capture never retracts a held word.
- Sources must update data/req on the edge where ack[i] is sampled high. A req still high after that edge is a new request.
- Single requester with out_ready tied high: that source is granted every cycle. ptr wraps 3->0.
- req=4'b1111 continuously with out_ready=1 gives grant order 0,1,2,3,0,...

Decomposition:
- Shared package/header:
  - state encoding localparams ST_IDLE, ST_HOLD;
  - NUM_SRC=4;
  - SEL_W=2.
- Sub-module: instantiate the existing `four_one_mux` (ports s,a,b,c,d,dout) for data selection, driven by the combinational winner index.
- Round-robin priority logic stays inline (about 30 lines). No further sub-module.

Test Plan:
- Reset: hold rst_n=0 two cycles with req=4'b1111 -> out_valid=0, out_data=0, sel=0, ack=0 throughout. First edge with rst_n=1 captures source 0.
- Single request: req=4'b0100, c=4'b1110, out_ready=1 -> next cycle: out_valid=1, sel=2, out_data=4'b1110, ack=4'b0100 for one cycle.
  - If req is dropped on ack: the following cycle out_valid=0, sel stays 2.
- Rotation: req=4'b1111, a=1, b=2, c=3, d=4, out_ready=1 for 8 cycles -> out_data sequence 1,2,3,4,1,2,3,4. ack walks 0001,0010,0100,1000 each cycle.
- Backpressure: capture source 1 (b=4'b0111), then out_ready=0 for 3 cycles while b changes to 4'b0000 and req toggles -> out_data stays 4'b0111, sel=1, out_valid=1, ack pulses only once.
  - On out_ready=1 the transfer completes and ptr=2.
- Fairness with skip: ptr=3 after a source-2 transfer, req=4'b0101 -> source 0 granted next (wrap), then source 2. Source 0 is not granted twice in a row.
- Reset mid-HOLD: word held with out_ready=0, then rst_n=0 one edge -> out_valid=0, ptr=0 the next cycle, and no ack is produced for the dropped word.
